// File: rtl/clock_display_scan_pkg.sv
// Shared display definitions: active-low 7-segment glyphs (SEG[6:0] = g..a),
// set-mode FLAG encodings and the snapshot record used by the scan back-end.
package clock_display_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] FLAG_RUN  = 2'b00;
  localparam logic [1:0] FLAG_HOUR = 2'b01;
  localparam logic [1:0] FLAG_MIN  = 2'b10;
  localparam logic [1:0] FLAG_SEC  = 2'b11;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic [7:0] centi;
    logic [1:0] flag;
  } snap_t;

  function automatic logic [6:0] bcd_glyph(input logic [3:0] d);
    case (d)
      4'd0:    bcd_glyph = SEG_0;
      4'd1:    bcd_glyph = SEG_1;
      4'd2:    bcd_glyph = SEG_2;
      4'd3:    bcd_glyph = SEG_3;
      4'd4:    bcd_glyph = SEG_4;
      4'd5:    bcd_glyph = SEG_5;
      4'd6:    bcd_glyph = SEG_6;
      4'd7:    bcd_glyph = SEG_7;
      4'd8:    bcd_glyph = SEG_8;
      4'd9:    bcd_glyph = SEG_9;
      default: bcd_glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/clock_display_scan_bin2bcd99.sv
// Combinational 0..99 binary to two BCD digits; values above 99 raise oor
// (digits are then meaningless and must not be displayed).
module bin2bcd99
  import clock_display_scan_pkg::*;
(
  input  logic [7:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       oor
);

  // Compare ladder instead of a divider: tens is the largest t with bin >= 10*t.
  always_comb begin
    tens = 4'd0;
    for (int t = 1; t < 10; t++) begin
      tens = (bin >= 8'(t * 10)) ? 4'(t) : tens;
    end
    units = 4'(bin - 8'(tens) * 8'd10);
    oor   = (bin > 8'd99);
  end

endmodule

// File: rtl/clock_display_scan.sv
// 8-digit multiplexed common-anode display driver: per-frame snapshot of the
// time fields, BCD conversion, digit scan with anti-ghost gap and set-mode blink.
module clock_display_scan
  import clock_display_scan_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int DIGIT_HZ = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] Hour,
  input  logic [7:0] Minute,
  input  logic [7:0] Second,
  input  logic [7:0] Centi_second,
  input  logic [1:0] FLAG,
  output logic [7:0] DIG,
  output logic [7:0] SEG
);

  localparam int DIV = CLK_HZ / DIGIT_HZ;
  localparam int HB  = CLK_HZ / (2 * BLINK_HZ);
  localparam int PCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = (HB > 1) ? $clog2(HB) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(DIV - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(HB - 1);

  logic [PCW-1:0] pc_q, pc_d;
  logic [2:0]     idx_q, idx_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic           bl_q, bl_d;
  logic           init_q, init_d;
  snap_t          snap_q, snap_d;
  logic [7:0]     dig_q, dig_d;
  logic [7:0]     seg_q, seg_d;

  snap_t      live_s, view_s;
  logic       pc_last_s, frame_end_s, blank_s, dp_n_s;
  logic [7:0] field_s;
  logic [1:0] sel_flag_s;
  logic [6:0] glyph_s;
  logic [3:0] tens_s, units_s;
  logic       oor_s;

  // Prescaler, scan index, blink timer and snapshot next-state.
  always_comb begin
    pc_last_s   = (pc_q == PC_LAST);
    frame_end_s = pc_last_s && (idx_q == 3'd0);
    pc_d        = pc_last_s ? {PCW{1'b0}} : pc_q + PCW'(1);
    idx_d       = pc_last_s ? idx_q - 3'd1 : idx_q;
    bc_d        = (bc_q == BC_LAST) ? {BCW{1'b0}} : bc_q + BCW'(1);
    bl_d        = (bc_q == BC_LAST) ? ~bl_q : bl_q;
    live_s      = '{hour: Hour, minute: Minute, second: Second,
                    centi: Centi_second, flag: FLAG};
    snap_d      = (init_q || frame_end_s) ? live_s : snap_q;
    init_d      = 1'b0;
    // The load cycle after reset already displays idx 7, so it sees the values being captured.
    view_s      = init_q ? live_s : snap_q;
  end

  // Field select for the digit being scanned; the default arm is Centi_second, which never blinks.
  always_comb begin
    case (idx_q[2:1])
      2'd3:    begin field_s = view_s.hour;   sel_flag_s = FLAG_HOUR; end
      2'd2:    begin field_s = view_s.minute; sel_flag_s = FLAG_MIN;  end
      2'd1:    begin field_s = view_s.second; sel_flag_s = FLAG_SEC;  end
      default: begin field_s = view_s.centi;  sel_flag_s = FLAG_RUN;  end
    endcase
  end

  bin2bcd99 u_bcd (
    .bin   (field_s),
    .tens  (tens_s),
    .units (units_s),
    .oor   (oor_s)
  );

  // Glyph, separator dot, blink blanking and anti-ghost digit gap.
  always_comb begin
    glyph_s = oor_s ? SEG_DASH : bcd_glyph(idx_q[0] ? tens_s : units_s);
    dp_n_s  = ~(~idx_q[0] && (idx_q != 3'd0));
    blank_s = bl_q && (view_s.flag != FLAG_RUN) && (view_s.flag == sel_flag_s);
    seg_d   = blank_s ? 8'hFF : {dp_n_s, glyph_s};
    dig_d   = pc_last_s ? 8'hFF : ~(8'b0000_0001 << idx_q);
  end

  // State and registered display outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q   <= {PCW{1'b0}};
      idx_q  <= 3'd7;
      bc_q   <= {BCW{1'b0}};
      bl_q   <= 1'b0;
      init_q <= 1'b1;
      snap_q <= '0;
      dig_q  <= 8'hFF;
      seg_q  <= 8'hFF;
    end else begin
      pc_q   <= pc_d;
      idx_q  <= idx_d;
      bc_q   <= bc_d;
      bl_q   <= bl_d;
      init_q <= init_d;
      snap_q <= snap_d;
      dig_q  <= dig_d;
      seg_q  <= seg_d;
    end
  end

  assign DIG = dig_q;
  assign SEG = seg_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan with DIV = 8 and HB = 8 cycles.
module tb_clock_display_scan;

  localparam int DIV   = 8;
  localparam int HB    = 8;
  localparam int FRAME = 8 * DIV;
  localparam logic [6:0] GL [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                     7'b0110000, 7'b0011001, 7'b0010010,
                                     7'b0000010, 7'b1111000, 7'b0000000,
                                     7'b0010000};
  localparam logic [6:0] DASH = 7'b0111111;

  logic       CLK;
  logic       RESET;
  logic [7:0] Hour, Minute, Second, Centi_second;
  logic [1:0] FLAG;
  logic [7:0] DIG, SEG;

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [7:0]  sh, sm, ss, sc;
  logic [1:0]  sf;
  logic [15:0] sb [$];

  clock_display_scan #(.CLK_HZ(8000), .DIGIT_HZ(1000), .BLINK_HZ(500)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .Hour         (Hour),
    .Minute       (Minute),
    .Second       (Second),
    .Centi_second (Centi_second),
    .FLAG         (FLAG),
    .DIG          (DIG),
    .SEG          (SEG)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got DIG/SEG %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input int ix, input int pc, input bit bl);
    int v, d;
    logic [7:0] dig, seg;
    logic [6:0] g;
    bit sel;
    case (ix / 2)
      3:       v = int'(sh);
      2:       v = int'(sm);
      1:       v = int'(ss);
      default: v = int'(sc);
    endcase
    d   = (ix % 2 == 1) ? v / 10 : v % 10;
    g   = (v > 99) ? DASH : GL[d];
    sel = (sf == 2'b01 && ix / 2 == 3) || (sf == 2'b10 && ix / 2 == 2) ||
          (sf == 2'b11 && ix / 2 == 1);
    seg = (sel && bl) ? 8'hFF : {((ix == 6 || ix == 4 || ix == 2) ? 1'b0 : 1'b1), g};
    dig = (pc == DIV - 1) ? 8'hFF : ~(8'h01 << ix);
    return {dig, seg};
  endfunction

  task automatic load_snap();
    sh = Hour; sm = Minute; ss = Second; sc = Centi_second; sf = FLAG;
  endtask

  // One clock: predict the output of the coming edge, then compare after it.
  task automatic cycle();
    int fr, ix, pc;
    bit bl;
    logic [15:0] e;
    fr = n % FRAME;
    ix = 7 - fr / DIV;
    pc = fr % DIV;
    bl = ((n / HB) % 2) == 1;
    if (n == 0) load_snap();
    sb.push_back(model(ix, pc, bl));
    if (fr == FRAME - 1) load_snap();
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check($sformatf("scan n=%0d", n), {DIG, SEG}, e);
    n++;
    @(negedge CLK);
  endtask

  task automatic run_to(input int target);
    while (n < target) cycle();
  endtask

  initial begin
    RESET = 1'b1;
    Hour = 8'd23; Minute = 8'd59; Second = 8'd50; Centi_second = 8'd0; FLAG = 2'b00;
    repeat (3) @(negedge CLK);
    check("reset", {DIG, SEG}, 16'hFFFF);

    RESET = 1'b0;
    n = 0;
    cycle();
    check("first_dig", {DIG, SEG}, {8'h7F, 8'hA4});
    run_to(64);

    Minute = 8'd120;
    run_to(146);
    check("dash_idx5", {DIG, SEG}, {8'hDF, 8'hBF});

    Minute = 8'd59; FLAG = 2'b10;
    run_to(210);
    check("blink_off_idx5", {DIG, SEG}, {8'hDF, 8'h92});
    run_to(218);
    check("blink_on_idx4", {DIG, SEG}, {8'hEF, 8'hFF});
    run_to(256);

    Second = 8'd49; FLAG = 2'b00;
    run_to(330);
    Second = 8'd50; FLAG = 2'b01;
    run_to(354);
    check("hold_49", {DIG, SEG}, {8'hF7, 8'h99});
    run_to(394);
    check("hour_blank", {DIG, SEG}, {8'hBF, 8'hFF});
    run_to(418);
    check("next_50", {DIG, SEG}, {8'hF7, 8'h92});
    run_to(450);

    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check("reset_async", {DIG, SEG}, 16'hFFFF);
    Hour = 8'd100; Centi_second = 8'd99; FLAG = 2'b00;
    @(negedge CLK);
    RESET = 1'b0;
    n = 0;
    cycle();
    check("rst_release", {DIG, SEG}, {8'h7F, 8'hBF});
    run_to(80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
